// File: rtl/sample_reader_pkg.sv
// Shared constants, register map and FSM state type for the sample buffer reader.
// The optional threshold-crossing registers are enabled by THRESHOLD_CROSS_EN.
package sample_reader_pkg;

  localparam int MEMORY_SIZE = 512;
  localparam int RD_LATENCY  = 1;
  localparam int ADDR_W      = $clog2(MEMORY_SIZE);
  localparam int LEN_W       = ADDR_W + 1;
  localparam int SUM_W       = 17;

  localparam logic [3:0] REG_CONTROL    = 4'd0;
  localparam logic [3:0] REG_STATUS     = 4'd1;
  localparam logic [3:0] REG_START_ADDR = 4'd2;
  localparam logic [3:0] REG_LENGTH     = 4'd3;
  localparam logic [3:0] REG_PEAK_VAL   = 4'd4;
  localparam logic [3:0] REG_PEAK_IDX   = 4'd5;
  localparam logic [3:0] REG_SUM        = 4'd6;
  localparam logic [3:0] REG_THRESHOLD  = 4'd7;
  localparam logic [3:0] REG_CROSS_IDX  = 4'd8;

  localparam int CTRL_START      = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_ABORT      = 2;
  localparam int STAT_DONE       = 0;
  localparam int STAT_BUSY       = 1;
  localparam int CROSS_FOUND_BIT = 15;

  localparam logic [31:0] DEFAULT_RDATA = 32'h0000_CCCC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A zero or oversized length means "the whole buffer".
  function automatic logic [LEN_W-1:0] effective_length(input logic [LEN_W-1:0] len);
    if (len == '0 || len > LEN_W'(MEMORY_SIZE)) return LEN_W'(MEMORY_SIZE);
    return len;
  endfunction

endpackage

// File: rtl/sample_reader_if.sv
// Bus interfaces of the sample reader: the Nios register slave and the RAM read master.
// Both buses are fixed-latency with no waitrequest: a slave read returns data one clk after
// avmms_read, and a RAM read returns avmm_readdata RD_LATENCY clk after avmm_read.
interface sample_reader_csr_if;
  logic        avmms_cs;
  logic [3:0]  avmms_address;
  logic        avmms_write;
  logic [31:0] avmms_writedata;
  logic        avmms_read;
  logic [31:0] avmms_readdata;
  logic        irq;

  modport master (
    output avmms_cs, avmms_address, avmms_write, avmms_writedata, avmms_read,
    input  avmms_readdata, irq
  );
  modport slave (
    input  avmms_cs, avmms_address, avmms_write, avmms_writedata, avmms_read,
    output avmms_readdata, irq
  );
endinterface

interface sample_reader_mem_if;
  logic                               avmm_cs;
  logic [sample_reader_pkg::ADDR_W-1:0] avmm_address;
  logic                               avmm_read;
  logic [7:0]                         avmm_readdata;

  modport master (
    output avmm_cs, avmm_address, avmm_read,
    input  avmm_readdata
  );
  modport slave (
    input  avmm_cs, avmm_address, avmm_read,
    output avmm_readdata
  );
endinterface

// File: rtl/sample_stats.sv
// Valid-gated accumulator: running sum, first-maximum peak with its window offset and,
// with THRESHOLD_CROSS_EN, the offset of the first sample at or above a threshold.
module sample_stats
  import sample_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [7:0]        data,
`ifdef THRESHOLD_CROSS_EN
  input  logic [7:0]        threshold,
  output logic [ADDR_W-1:0] cross_idx,
  output logic              cross_found,
`endif
  output logic [7:0]        peak_val,
  output logic [ADDR_W-1:0] peak_idx,
  output logic [SUM_W-1:0]  sum
);

  logic [ADDR_W-1:0] offset_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      offset_q <= '0;
      peak_val <= '0;
      peak_idx <= '0;
      sum      <= '0;
    end else if (valid) begin
      offset_q <= offset_q + 1'b1;
      sum      <= sum + SUM_W'(data);
      // Strict compare keeps the earliest of equal maxima.
      if (data > peak_val) begin
        peak_val <= data;
        peak_idx <= offset_q;
      end
    end
  end

`ifdef THRESHOLD_CROSS_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cross_idx   <= '0;
      cross_found <= 1'b0;
    end else if (valid && !cross_found && data >= threshold) begin
      cross_idx   <= offset_q;
      cross_found <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sample_reader.sv
// Streams a programmed window of the sample RAM and reports peak, peak index and sum.
// Optional threshold-crossing registers (7, 8) are built only with THRESHOLD_CROSS_EN.
module sample_reader
  import sample_reader_pkg::*;
(
  input  logic                avmms_clk,
  input  logic                avmms_reset,
  sample_reader_csr_if.slave  csr,
  sample_reader_mem_if.master mem,
  output state_t              dbg_state
);

  state_t            state_q, state_d;
  logic              irq_en_q, done_q, irq_q, valid_q;
  logic [ADDR_W-1:0] start_addr_q, addr_q;
  logic [LEN_W-1:0]  length_q, issue_cnt_q, eff_len;
  logic [31:0]       rdata_q, rdata_d;
  logic [7:0]        peak_val;
  logic [ADDR_W-1:0] peak_idx;
  logic [SUM_W-1:0]  sum;
  logic              wr_en, rd_en, busy, issuing, last_issue;
  logic              start_go, abort_wr, done_clr;
  logic              unused_wdata_bits;
`ifdef THRESHOLD_CROSS_EN
  logic [7:0]        threshold_q;
  logic [ADDR_W-1:0] cross_idx;
  logic              cross_found;
`endif

  assign wr_en      = csr.avmms_cs && csr.avmms_write;
  assign rd_en      = csr.avmms_cs && csr.avmms_read;
  assign busy       = (state_q != ST_IDLE);
  assign issuing    = (state_q == ST_READ);
  assign eff_len    = effective_length(length_q);
  assign last_issue = (issue_cnt_q == eff_len - 1'b1);
  assign start_go   = wr_en && csr.avmms_address == REG_CONTROL
                      && csr.avmms_writedata[CTRL_START] && !busy;
  assign abort_wr   = wr_en && csr.avmms_address == REG_CONTROL
                      && csr.avmms_writedata[CTRL_ABORT];
  assign done_clr   = wr_en && csr.avmms_address == REG_STATUS
                      && csr.avmms_writedata[STAT_DONE];
  assign unused_wdata_bits = ^csr.avmms_writedata[31:LEN_W];

  always_ff @(posedge avmms_clk) begin
    if (avmms_reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_go) state_d = ST_READ;
      ST_READ: begin
        if (abort_wr)        state_d = ST_IDLE;
        else if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = abort_wr ? ST_IDLE : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign dbg_state        = state_q;
  assign mem.avmm_cs      = issuing;
  assign mem.avmm_read    = issuing;
  assign mem.avmm_address = addr_q;

  // Address wraps naturally at the buffer end since ADDR_W covers exactly MEMORY_SIZE.
  always_ff @(posedge avmms_clk) begin
    if (avmms_reset) begin
      addr_q      <= '0;
      issue_cnt_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= issuing;
      if (start_go) begin
        addr_q      <= start_addr_q;
        issue_cnt_q <= '0;
      end else if (issuing) begin
        addr_q      <= addr_q + 1'b1;
        issue_cnt_q <= issue_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge avmms_clk) begin
    if (avmms_reset) begin
      irq_en_q     <= 1'b0;
      start_addr_q <= '0;
      length_q     <= '0;
      done_q       <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      if (wr_en && csr.avmms_address == REG_CONTROL)
        irq_en_q <= csr.avmms_writedata[CTRL_IRQ_EN];
      if (wr_en && !busy && csr.avmms_address == REG_START_ADDR)
        start_addr_q <= csr.avmms_writedata[ADDR_W-1:0];
      if (wr_en && !busy && csr.avmms_address == REG_LENGTH)
        length_q <= csr.avmms_writedata[LEN_W-1:0];
      // Completion has priority over a simultaneous clear.
      if (state_q == ST_DONE)      done_q <= 1'b1;
      else if (start_go || done_clr) done_q <= 1'b0;
      irq_q <= done_q && irq_en_q;
    end
  end

`ifdef THRESHOLD_CROSS_EN
  always_ff @(posedge avmms_clk) begin
    if (avmms_reset)
      threshold_q <= '0;
    else if (wr_en && !busy && csr.avmms_address == REG_THRESHOLD)
      threshold_q <= csr.avmms_writedata[7:0];
  end
`endif

  sample_stats u_stats (
    .clk         (avmms_clk),
    .rst         (avmms_reset),
    .clear       (start_go),
    .valid       (valid_q),
    .data        (mem.avmm_readdata),
`ifdef THRESHOLD_CROSS_EN
    .threshold   (threshold_q),
    .cross_idx   (cross_idx),
    .cross_found (cross_found),
`endif
    .peak_val    (peak_val),
    .peak_idx    (peak_idx),
    .sum         (sum)
  );

  always_comb begin
    rdata_d = '0;
    case (csr.avmms_address)
      REG_CONTROL:    rdata_d[CTRL_IRQ_EN] = irq_en_q;
      REG_STATUS: begin
        rdata_d[STAT_DONE] = done_q;
        rdata_d[STAT_BUSY] = busy;
      end
      REG_START_ADDR: rdata_d[ADDR_W-1:0] = start_addr_q;
      REG_LENGTH:     rdata_d[LEN_W-1:0]  = length_q;
      REG_PEAK_VAL:   rdata_d[7:0]        = peak_val;
      REG_PEAK_IDX:   rdata_d[ADDR_W-1:0] = peak_idx;
      REG_SUM:        rdata_d[SUM_W-1:0]  = sum;
`ifdef THRESHOLD_CROSS_EN
      REG_THRESHOLD:  rdata_d[7:0]        = threshold_q;
      REG_CROSS_IDX: begin
        rdata_d[ADDR_W-1:0]      = cross_idx;
        rdata_d[CROSS_FOUND_BIT] = cross_found;
      end
`endif
      default:        rdata_d = DEFAULT_RDATA;
    endcase
  end

  always_ff @(posedge avmms_clk) begin
    if (avmms_reset) rdata_q <= '0;
    else if (rd_en)  rdata_q <= rdata_d;
  end

  assign csr.avmms_readdata = rdata_q;
  assign csr.irq            = irq_q;

endmodule

// File: tb/tb_sample_reader.sv
// Directed bench for sample_reader: table of windows over a modelled RAM plus
// hand-written sequences for busy writes, abort, reset and the optional crossing feature.
module tb_sample_reader;
  import sample_reader_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_fail   = 0;

  sample_reader_csr_if csr_bus ();
  sample_reader_mem_if mem_bus ();

  sample_reader dut (
    .avmms_clk   (clk),
    .avmms_reset (rst),
    .csr         (csr_bus.slave),
    .mem         (mem_bus.master),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model and read log ----------------
  logic [7:0]        ram [MEMORY_SIZE];
  logic [7:0]        ram_q = '0;
  logic [ADDR_W-1:0] addr_log [$];
  logic [ADDR_W-1:0] exp_q [$];

  assign mem_bus.avmm_readdata = ram_q;

  always @(posedge clk) begin
    if (mem_bus.avmm_cs && mem_bus.avmm_read) begin
      ram_q <= ram[mem_bus.avmm_address];
      addr_log.push_back(mem_bus.avmm_address);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < MEMORY_SIZE; i++) begin
      case (mode)
        0: ram[i] = 8'(i);
        1: ram[i] = 8'hFF;
        2: ram[i] = 8'h00;
        default: ram[i] = (i < 4) ? 8'((i + 1) * 10) : 8'h00;
      endcase
    end
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    csr_bus.avmms_cs        = 1'b1;
    csr_bus.avmms_write     = 1'b1;
    csr_bus.avmms_address   = a;
    csr_bus.avmms_writedata = d;
    @(posedge clk);
    #1;
    csr_bus.avmms_cs    = 1'b0;
    csr_bus.avmms_write = 1'b0;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
    csr_bus.avmms_cs      = 1'b1;
    csr_bus.avmms_read    = 1'b1;
    csr_bus.avmms_address = a;
    @(posedge clk);
    #1;
    csr_bus.avmms_cs   = 1'b0;
    csr_bus.avmms_read = 1'b0;
    d = csr_bus.avmms_readdata;
  endtask

  // Starts a window with irq enabled and counts clocks (the start edge is 1) until irq.
  task automatic start_window(input logic [ADDR_W-1:0] sa, input logic [LEN_W-1:0] len);
    csr_write(REG_START_ADDR, 32'(sa));
    csr_write(REG_LENGTH, 32'(len));
    addr_log.delete();
    csr_write(REG_CONTROL, 32'h3);
  endtask

  task automatic wait_irq(inout int cycles);
    while (csr_bus.irq !== 1'b1 && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic clear_done();
    csr_write(REG_STATUS, 32'h1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int                mode;
    logic [ADDR_W-1:0] start;
    logic [LEN_W-1:0]  len;
    int                n_reads;
    logic [7:0]        peak;
    logic [ADDR_W-1:0] idx;
    logic [SUM_W-1:0]  sum;
    int                cycles;   // clocks from start edge to irq (done + 1)
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0]       rd;
    int                cyc;
    int                err;
    int                n_before;
    logic [ADDR_W-1:0] a;

    vecs[0] = '{0, 9'd0,   10'd16,  16,  8'd15,  9'd15,  17'd120,    20};
    vecs[1] = '{0, 9'd508, 10'd8,   8,   8'd255, 9'd3,   17'd1020,   12};
    vecs[2] = '{1, 9'd0,   10'd0,   512, 8'd255, 9'd0,   17'd130560, 516};
    vecs[3] = '{0, 9'd100, 10'd600, 512, 8'd255, 9'd155, 17'd65280,  516};
    vecs[4] = '{0, 9'd300, 10'd1,   1,   8'd44,  9'd0,   17'd44,     5};
    vecs[5] = '{2, 9'd7,   10'd5,   5,   8'd0,   9'd0,   17'd0,      9};

    csr_bus.avmms_cs        = 1'b0;
    csr_bus.avmms_address   = '0;
    csr_bus.avmms_write     = 1'b0;
    csr_bus.avmms_writedata = '0;
    csr_bus.avmms_read      = 1'b0;
    rst = 1'b1;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {mem_bus.avmm_cs, mem_bus.avmm_read, csr_bus.irq, 29'(mem_bus.avmm_address)}, 32'h0);
    check("reset_readdata", csr_bus.avmms_readdata, 32'h0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    csr_read(REG_CONTROL, rd);    check("reset_control", rd, 32'h0);
    csr_read(REG_STATUS, rd);     check("reset_status", rd, 32'h0);
    csr_read(REG_START_ADDR, rd); check("reset_start_addr", rd, 32'h0);
    csr_read(REG_SUM, rd);        check("reset_sum", rd, 32'h0);
    csr_read(4'd9, rd);           check("unmapped_9", rd, 32'h0000CCCC);
    csr_read(4'd15, rd);          check("unmapped_15", rd, 32'h0000CCCC);
`ifndef THRESHOLD_CROSS_EN
    csr_write(REG_THRESHOLD, 32'h55);
    csr_read(REG_THRESHOLD, rd);  check("absent_threshold", rd, 32'h0000CCCC);
    csr_read(REG_CROSS_IDX, rd);  check("absent_cross_idx", rd, 32'h0000CCCC);
`endif

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].mode);
      start_window(vecs[v].start, vecs[v].len);
      cyc = 1;
      wait_irq(cyc);
      check($sformatf("v%0d_latency", v), 32'(cyc), 32'(vecs[v].cycles));
      csr_read(REG_STATUS, rd);   check($sformatf("v%0d_status", v), rd, 32'h1);
      csr_read(REG_PEAK_VAL, rd); check($sformatf("v%0d_peak_val", v), rd, 32'(vecs[v].peak));
      csr_read(REG_PEAK_IDX, rd); check($sformatf("v%0d_peak_idx", v), rd, 32'(vecs[v].idx));
      csr_read(REG_SUM, rd);      check($sformatf("v%0d_sum", v), rd, 32'(vecs[v].sum));
      exp_q.delete();
      for (int k = 0; k < vecs[v].n_reads; k++) begin
        a = vecs[v].start + ADDR_W'(k);
        exp_q.push_back(a);
      end
      check($sformatf("v%0d_read_count", v), 32'(addr_log.size()), 32'(exp_q.size()));
      err = 0;
      for (int k = 0; k < exp_q.size() && k < addr_log.size(); k++)
        if (addr_log[k] !== exp_q[k]) err++;
      check($sformatf("v%0d_addr_seq_errors", v), 32'(err), 32'h0);
      clear_done();
      check($sformatf("v%0d_irq_cleared", v), 32'(csr_bus.irq), 32'h0);
    end

    // Start and start_addr writes while busy are ignored.
    fill(0);
    start_window(9'd0, 10'd16);
    csr_write(REG_START_ADDR, 32'd200);
    csr_write(REG_CONTROL, 32'h3);
    cyc = 3;
    wait_irq(cyc);
    check("busy_latency", 32'(cyc), 32'd20);
    check("busy_read_count", 32'(addr_log.size()), 32'd16);
    csr_read(REG_SUM, rd);        check("busy_sum", rd, 32'd120);
    csr_read(REG_PEAK_VAL, rd);   check("busy_peak_val", rd, 32'd15);
    csr_read(REG_START_ADDR, rd); check("busy_start_addr", rd, 32'd0);
    clear_done();

    // Abort mid-READ.
    start_window(9'd0, 10'd100);
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_read", 32'(mem_bus.avmm_read), 32'h1);
    csr_write(REG_CONTROL, 32'h6);
    check("abort_read_low", 32'(mem_bus.avmm_read), 32'h0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    n_before = addr_log.size();
    csr_read(REG_STATUS, rd);     check("abort_status", rd, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_reads", 32'(addr_log.size()), 32'(n_before));
    check("abort_irq", 32'(csr_bus.irq), 32'h0);

    // Synchronous reset mid-READ.
    start_window(9'd5, 10'd100);
    csr_read(REG_STATUS, rd);     check("rst_busy_status", rd, 32'h2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mem_outputs", {mem_bus.avmm_cs, mem_bus.avmm_read, 30'(mem_bus.avmm_address)}, 32'h0);
    check("rst_readdata", csr_bus.avmms_readdata, 32'h0);
    check("rst_irq", 32'(csr_bus.irq), 32'h0);
    rst = 1'b0;
    n_before = addr_log.size();
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_reads", 32'(addr_log.size()), 32'(n_before));
    csr_read(REG_LENGTH, rd);     check("rst_length", rd, 32'h0);

`ifdef THRESHOLD_CROSS_EN
    fill(3);
    csr_write(REG_THRESHOLD, 32'd25);
    csr_read(REG_THRESHOLD, rd);  check("thr_readback", rd, 32'd25);
    start_window(9'd0, 10'd4);
    cyc = 1;
    wait_irq(cyc);
    csr_read(REG_CROSS_IDX, rd);  check("cross_found_25", rd, 32'h0000_8002);
    csr_read(REG_SUM, rd);        check("cross_sum", rd, 32'd100);
    clear_done();
    csr_write(REG_THRESHOLD, 32'd50);
    start_window(9'd0, 10'd4);
    cyc = 1;
    wait_irq(cyc);
    csr_read(REG_CROSS_IDX, rd);  check("cross_none_50", rd, 32'h0);
    clear_done();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
